// File: rtl/prim_ram_1p_host_adapter.sv
// Host-side front end for a single-port SRAM: valid/ready requests in, ordered read responses out,
// with credit-based backpressure, a bypass path for the 1-cycle read latency and optional zero-fill.
module prim_ram_1p_host_adapter #(
    parameter int unsigned Width       = 32,
    parameter int unsigned Depth       = 128,
    parameter int unsigned RspDepth    = 2,
    parameter bit          InitOnReset = 1'b1,
    localparam int unsigned Aw         = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             init_done_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i
);

    typedef enum logic {StInit, StRun} state_e;

    localparam int unsigned   PtrW     = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int unsigned   CntW     = $clog2(RspDepth + 1);
    localparam logic [Aw-1:0] LastAddr = Aw'(Depth - 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(RspDepth - 1);
    localparam logic [CntW:0] Credits  = (CntW + 1)'(RspDepth);

    state_e            state_q, state_d;
    logic [Aw-1:0]     cnt_q, cnt_d;
    logic [Width-1:0]  fifo_q [RspDepth];
    logic [PtrW-1:0]   wptr_q, rptr_q;
    logic [CntW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic              rd_inflight_q, rd_inflight_d;

    logic              fifo_empty, fifo_full, push, pop, credit_ok;
    logic [CntW:0]     credits_used;

    // A slot is reserved for every read still in flight, so the FIFO can never overflow.
    assign credits_used = {1'b0, fifo_cnt_q} + (CntW + 1)'(rd_inflight_q);
    assign credit_ok    = credits_used < Credits;

    assign fifo_empty  = (fifo_cnt_q == '0);
    assign fifo_full   = (fifo_cnt_q == CntW'(RspDepth));
    assign rsp_valid_o = rst_ni & (~fifo_empty | rd_inflight_q);
    assign rsp_rdata_o = fifo_empty ? ram_rdata_i : fifo_q[rptr_q];
    assign push        = rd_inflight_q & ~(fifo_empty & rsp_ready_i);
    assign pop         = ~fifo_empty & rsp_ready_i;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_ready_o   = 1'b0;
        init_done_o   = 1'b0;
        rd_inflight_d = 1'b0;
        ram_req_o     = 1'b0;
        ram_write_o   = req_write_i;
        ram_addr_o    = req_addr_i;
        ram_wdata_o   = req_wdata_i;
        ram_wmask_o   = req_wmask_i;
        if (rst_ni) begin
            unique case (state_q)
                StInit: begin
                    ram_req_o   = 1'b1;
                    ram_write_o = 1'b1;
                    ram_addr_o  = cnt_q;
                    ram_wdata_o = '0;
                    ram_wmask_o = '1;
                    if (cnt_q == LastAddr) begin
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    init_done_o   = 1'b1;
                    req_ready_o   = credit_ok;
                    ram_req_o     = req_valid_i & credit_ok;
                    rd_inflight_d = req_valid_i & credit_ok & ~req_write_i;
                end
                default: state_d = StInit;
            endcase
        end
    end

    always_comb begin
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= InitOnReset ? StInit : StRun;
            cnt_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            fifo_cnt_q    <= '0;
            rd_inflight_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            fifo_cnt_q    <= fifo_cnt_d;
            rd_inflight_q <= rd_inflight_d;
            if (push) wptr_q <= ptr_inc(wptr_q);
            if (pop)  rptr_q <= ptr_inc(rptr_q);
        end
    end

    // NOTE: FIFO storage is not reset; the count and pointers alone decide which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wptr_q] <= ram_rdata_i;
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full));

endmodule
